// File: rtl/rx_cmd_ctrl.sv
// rx_cmd_ctrl: receive-side command controller behind the UART receiver.
// Decodes write / read / ALU packets from received bytes, drives the register
// file and ALU, and returns read data or ALU results through a valid/ready
// byte handshake. Every multi-byte packet and every response wait is guarded
// by an idle timeout.
module rx_cmd_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int FUN_W    = 4,
    parameter int TIMEOUT  = 1023,
    parameter int OPA_ADDR = 0,
    parameter int OPB_ADDR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [7:0]        rf_wr_data,
    input  logic [7:0]        rf_rd_data,
    input  logic              rf_rd_valid,
    output logic              alu_en,
    output logic [FUN_W-1:0]  alu_fun,
    input  logic [15:0]       alu_out,
    input  logic              alu_out_valid,
    output logic              clk_gate_en,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              cmd_err,
    output logic              timeout_err,
    output logic              drop_err
);

    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] OPA_A   = ADDR_W'(OPA_ADDR);
    localparam logic [ADDR_W-1:0] OPB_A   = ADDR_W'(OPB_ADDR);

    localparam logic [7:0] CMD_WR  = 8'hAA;
    localparam logic [7:0] CMD_RD  = 8'hBB;
    localparam logic [7:0] CMD_ALU = 8'hCC;
    localparam logic [7:0] CMD_FUN = 8'hDD;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        OPA,
        OPB,
        FUN,
        RF_WAIT,
        ALU_WAIT,
        TX_LO,
        TX_HI
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic              two_q, two_d;
    logic              expire;
    logic              abort;
    logic              running;

    logic              rf_wr_en_d, rf_rd_en_d, alu_en_d;
    logic [ADDR_W-1:0] rf_addr_d;
    logic [7:0]        rf_wr_data_d, tx_data_d;
    logic [FUN_W-1:0]  alu_fun_d;
    logic              tx_valid_d, cmd_err_d, timeout_err_d, drop_err_d;

    assign expire = (cnt == CNT_MAX);

    // Next-state, next-output and timeout-counter decode for the packet FSM
    always_comb begin
        state_d       = state;
        addr_d        = addr_q;
        hi_d          = hi_q;
        two_d         = two_q;
        abort         = 1'b0;
        rf_wr_en_d    = 1'b0;
        rf_rd_en_d    = 1'b0;
        rf_addr_d     = rf_addr;
        rf_wr_data_d  = rf_wr_data;
        alu_en_d      = 1'b0;
        alu_fun_d     = alu_fun;
        tx_data_d     = tx_data;
        tx_valid_d    = tx_valid;
        cmd_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        drop_err_d    = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_WR:  state_d = WR_ADDR;
                        CMD_RD:  state_d = RD_ADDR;
                        CMD_ALU: state_d = OPA;
                        CMD_FUN: state_d = FUN;
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            WR_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data[ADDR_W-1:0];
                    state_d = WR_DATA;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            WR_DATA: begin
                if (rx_valid) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = addr_q;
                    rf_wr_data_d = rx_data;
                    state_d      = IDLE;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            RD_ADDR: begin
                if (rx_valid) begin
                    rf_rd_en_d = 1'b1;
                    rf_addr_d  = rx_data[ADDR_W-1:0];
                    state_d    = RF_WAIT;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            OPA: begin
                if (rx_valid) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = OPA_A;
                    rf_wr_data_d = rx_data;
                    state_d      = OPB;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            OPB: begin
                if (rx_valid) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = OPB_A;
                    rf_wr_data_d = rx_data;
                    state_d      = FUN;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            FUN: begin
                if (rx_valid) begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = rx_data[FUN_W-1:0];
                    state_d   = ALU_WAIT;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            RF_WAIT: begin
                drop_err_d = rx_valid;
                if (rf_rd_valid) begin
                    tx_data_d  = rf_rd_data;
                    tx_valid_d = 1'b1;
                    two_d      = 1'b0;
                    state_d    = TX_LO;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            ALU_WAIT: begin
                drop_err_d = rx_valid;
                if (alu_out_valid) begin
                    tx_data_d  = alu_out[7:0];
                    hi_d       = alu_out[15:8];
                    tx_valid_d = 1'b1;
                    two_d      = 1'b1;
                    state_d    = TX_LO;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            TX_LO: begin
                drop_err_d = rx_valid;
                if (tx_valid && tx_ready) begin
                    if (two_q) begin
                        tx_data_d = hi_q;
                        state_d   = TX_HI;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            TX_HI: begin
                drop_err_d = rx_valid;
                if (tx_valid && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

        if (abort) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
        end

        running = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR) ||
                  (state == OPA)     || (state == OPB)     || (state == FUN)     ||
                  (state == RF_WAIT) || (state == ALU_WAIT);
        if ((state_d != state) || !running) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt + CNT_W'(1);
        end
    end

    // State, context and registered-output update; reset aborts any packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            hi_q        <= '0;
            two_q       <= 1'b0;
            rf_wr_en    <= 1'b0;
            rf_rd_en    <= 1'b0;
            rf_addr     <= '0;
            rf_wr_data  <= '0;
            alu_en      <= 1'b0;
            alu_fun     <= '0;
            clk_gate_en <= 1'b0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            cmd_err     <= 1'b0;
            timeout_err <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            addr_q      <= addr_d;
            hi_q        <= hi_d;
            two_q       <= two_d;
            rf_wr_en    <= rf_wr_en_d;
            rf_rd_en    <= rf_rd_en_d;
            rf_addr     <= rf_addr_d;
            rf_wr_data  <= rf_wr_data_d;
            alu_en      <= alu_en_d;
            alu_fun     <= alu_fun_d;
            clk_gate_en <= (state_d == FUN) || (state_d == ALU_WAIT);
            tx_data     <= tx_data_d;
            tx_valid    <= tx_valid_d;
            busy        <= (state_d != IDLE);
            cmd_err     <= cmd_err_d;
            timeout_err <= timeout_err_d;
            drop_err    <= drop_err_d;
        end
    end

endmodule
